// File: rtl/pix_capture_pkg.sv
// pix_capture_pkg: shared types and widths for the pixel capture controller
package pix_capture_pkg;
  localparam int PIX_W   = 25;
  localparam int COORD_W = 12;
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_FRAME = 3'd1,
    ST_WAIT_TRIG  = 3'd2,
    ST_CAPTURE    = 3'd3,
    ST_DONE       = 3'd4
  } state_t;
endpackage

// File: rtl/capture_ram.sv
// capture_ram: simple dual-port sample buffer with registered read, read-before-write
module capture_ram
  import pix_capture_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_we,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [PIX_W-1:0] i_wr_data,
  input  logic             i_re,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [PIX_W-1:0] o_rd_data
);
  logic [PIX_W-1:0] r_mem [DEPTH];
  logic [PIX_W-1:0] r_rd_data;
  // write port; contents are never cleared
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_wr_addr] <= i_wr_data;
  end
  // registered read port; same-address collision returns the previous word
  always_ff @(posedge clk) begin
    if (!rst_n) r_rd_data <= '0;
    else if (i_re) r_rd_data <= r_mem[i_rd_addr];
  end
  assign o_rd_data = r_rd_data;
endmodule

// File: rtl/pix_capture_ctrl.sv
// pix_capture_ctrl: triggered pixel-stream capture into an on-chip buffer
module pix_capture_ctrl
  import pix_capture_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             de,
  input  logic [7:0]       red,
  input  logic [7:0]       green,
  input  logic [7:0]       blue,
  input  logic             vsync,
  input  logic             arm,
  input  logic             abort,
  input  logic [11:0]      trig_x,
  input  logic [11:0]      trig_y,
  input  logic [AW:0]      cap_len,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [PIX_W-1:0] rd_data,
  output logic             rd_valid,
  output logic             busy,
  output logic             done,
  output logic [AW:0]      wr_count,
  output logic [2:0]       state
);
  state_t             r_state, w_next;
  logic               r_vs_d, r_de_d, r_rd_valid;
  logic [COORD_W-1:0] r_x, r_y, r_trig_x, r_trig_y;
  logic [AW:0]        r_len, r_wr_count, w_len;
  logic               w_vs_rise, w_de_fall, w_match, w_arm, w_we, w_last;

  assign w_vs_rise = vsync & ~r_vs_d;
  assign w_de_fall = ~de & r_de_d;
  assign w_match   = de && !w_vs_rise && r_x == r_trig_x && r_y == r_trig_y;
  assign w_arm     = arm && !abort && (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_we      = rst_n && !abort &&
                     ((r_state == ST_WAIT_TRIG && w_match) || (r_state == ST_CAPTURE && de));
  assign w_last    = r_wr_count + (AW+1)'(1) >= r_len;
  assign w_len     = cap_len == '0 ? (AW+1)'(1) :
                     cap_len > (AW+1)'(DEPTH) ? (AW+1)'(DEPTH) : cap_len;

  // sync edge detectors and saturating raster coordinates
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vs_d <= 1'b0;
      r_de_d <= 1'b0;
      r_x    <= '0;
      r_y    <= '0;
    end else begin
      r_vs_d <= vsync;
      r_de_d <= de;
      if (w_vs_rise) begin
        r_x <= '0;
        r_y <= '0;
      end else if (w_de_fall) begin
        r_x <= '0;
        if (r_y != '1) r_y <= r_y + 1'b1;
      end else if (de && r_x != '1) begin
        r_x <= r_x + 1'b1;
      end
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else r_state <= w_next;
  end

  // next-state logic; abort overrides everything
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:       w_next = w_arm ? ST_WAIT_FRAME : ST_IDLE;
      ST_WAIT_FRAME: w_next = w_vs_rise ? ST_WAIT_TRIG : ST_WAIT_FRAME;
      ST_WAIT_TRIG:  w_next = w_we ? (w_last ? ST_DONE : ST_CAPTURE) : ST_WAIT_TRIG;
      ST_CAPTURE:    w_next = w_we && w_last ? ST_DONE : ST_CAPTURE;
      ST_DONE:       w_next = w_arm ? ST_WAIT_FRAME : ST_DONE;
      default:       w_next = ST_IDLE;
    endcase
    if (abort) w_next = ST_IDLE;
  end

  // state-decoded outputs
  always_comb begin
    busy  = r_state == ST_WAIT_FRAME || r_state == ST_WAIT_TRIG || r_state == ST_CAPTURE;
    done  = r_state == ST_DONE;
    state = r_state;
  end

  // arm-time latches and write counter; the counter doubles as write address
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_len      <= '0;
      r_trig_x   <= '0;
      r_trig_y   <= '0;
      r_wr_count <= '0;
    end else if (w_arm) begin
      r_len      <= w_len;
      r_trig_x   <= trig_x;
      r_trig_y   <= trig_y;
      r_wr_count <= '0;
    end else if (w_we) begin
      r_wr_count <= r_wr_count + 1'b1;
    end
  end

  // read-valid follows read request by one cycle
  always_ff @(posedge clk) begin
    if (!rst_n) r_rd_valid <= 1'b0;
    else r_rd_valid <= rd_en;
  end

  assign wr_count = r_wr_count;
  assign rd_valid = r_rd_valid;

  capture_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_we      (w_we),
    .i_wr_addr (r_wr_count[AW-1:0]),
    .i_wr_data ({de, red, green, blue}),
    .i_re      (rd_en),
    .i_rd_addr (rd_addr),
    .o_rd_data (rd_data)
  );
endmodule
